onehot_stream_demux: RTL and testbench

- Routes one valid/ready input stream to one of N output streams, chosen per transfer by a one-hot select carried with the data.
- Counterpart of the one-hot mux: fans an issue or response stream out to N consumers (per-warp, per-bank or per-unit queues).
- Registered output: one pipeline stage holds data plus its one-hot destination until that consumer accepts it.
- Flags malformed selects.

---
 rtl/onehot_stream_demux_if.sv | 25 ++
 rtl/onehot_stream_demux.sv | 104 ++++++++++
 tb/tb_onehot_stream_demux.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/onehot_stream_demux_if.sv
// Stream bundle for onehot_stream_demux: one input stream, N one-hot-routed output lanes.
// The slave modport is the demux; the master modport is the producer/consumer side.
interface onehot_stream_demux_if #(
  parameter int DATAW = 1,
  parameter int N     = 2
);
  logic                      valid_in;
  logic [DATAW-1:0]          data_in;
  logic [N-1:0]              sel_in;
  logic                      ready_in;
  logic [N-1:0]              valid_out;
  logic [N-1:0][DATAW-1:0]   data_out;
  logic [N-1:0]              ready_out;
  logic                      sel_err;

  modport slave (
    input  valid_in, data_in, sel_in, ready_out,
    output ready_in, valid_out, data_out, sel_err
  );

  modport master (
    output valid_in, data_in, sel_in, ready_out,
    input  ready_in, valid_out, data_out, sel_err
  );
endinterface

// File: rtl/onehot_stream_demux.sv
// Registered one-hot stream demux: one valid/ready input fanned out to N lanes, sticky bad-select flag.
// Define ONEHOT_DEMUX_SKID_EN to add a skid entry and make ready_in a pure register output.
module onehot_stream_demux #(
  parameter int DATAW = 1,
  parameter int N     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  onehot_stream_demux_if.slave   bus
);

  logic             valid_r;
  logic [N-1:0]     sel_r;
  logic [DATAW-1:0] data_r;
  logic             err_r;

  logic             fire_in;
  logic             fire_out;
  logic [N-1:0]     sel_norm;
  logic             sel_zero;
  logic             sel_bad;

  // Isolate the lowest set bit; a multi-hot select collapses onto its lowest lane.
  assign sel_norm = bus.sel_in & (~bus.sel_in + N'(1));
  assign sel_zero = (bus.sel_in == '0);
  assign sel_bad  = sel_zero || ((bus.sel_in & (bus.sel_in - N'(1))) != '0);

  assign fire_out = valid_r & (|(sel_r & bus.ready_out));
  assign fire_in  = bus.valid_in & bus.ready_in;

  assign bus.valid_out = {N{valid_r}} & sel_r;
  assign bus.data_out  = {N{data_r}};
  assign bus.sel_err   = err_r;

`ifdef ONEHOT_DEMUX_SKID_EN

  logic             sk_valid;
  logic [N-1:0]     sk_sel;
  logic [DATAW-1:0] sk_data;

  assign bus.ready_in = ~sk_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r  <= 1'b0;
      sel_r    <= '0;
      data_r   <= '0;
      err_r    <= 1'b0;
      sk_valid <= 1'b0;
      sk_sel   <= '0;
      sk_data  <= '0;
    end else begin
      if (fire_in && sel_bad)
        err_r <= 1'b1;
      // ready_in is low while the skid is full, so no input can arrive in that branch.
      if (sk_valid) begin
        if (fire_out) begin
          valid_r  <= 1'b1;
          sel_r    <= sk_sel;
          data_r   <= sk_data;
          sk_valid <= 1'b0;
        end
      end else if (!valid_r || fire_out) begin
        if (fire_in) begin
          valid_r <= !sel_zero;
          sel_r   <= sel_norm;
          data_r  <= bus.data_in;
        end else begin
          valid_r <= 1'b0;
        end
      end else if (fire_in && !sel_zero) begin
        sk_valid <= 1'b1;
        sk_sel   <= sel_norm;
        sk_data  <= bus.data_in;
      end
    end
  end

`else

  assign bus.ready_in = ~valid_r | fire_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      sel_r   <= '0;
      data_r  <= '0;
      err_r   <= 1'b0;
    end else begin
      if (fire_in && sel_bad)
        err_r <= 1'b1;
      if (fire_in) begin
        valid_r <= !sel_zero;
        sel_r   <= sel_norm;
        data_r  <= bus.data_in;
      end else if (fire_out) begin
        valid_r <= 1'b0;
      end
    end
  end

`endif

endmodule

// File: tb/tb_onehot_stream_demux.sv
// Scoreboard bench for onehot_stream_demux (N=4, DATAW=8): directed cases then random traffic.
module tb_onehot_stream_demux;

  localparam int N = 4;
  localparam int DATAW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  onehot_stream_demux_if #(.DATAW(DATAW), .N(N)) bus ();

  onehot_stream_demux #(.DATAW(DATAW), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               lane;
    logic [DATAW-1:0] data;
  } ent_t;

  ent_t q[$];
  logic exp_err = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;
  logic rdy_rand = 1'b0;
  logic [N-1:0] rdy_fix = '1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lane_of(input logic [N-1:0] s);
    for (int i = 0; i < N; i++)
      if (s[i]) return i;
    return -1;
  endfunction

  // One cycle of stimulus starting just after a rising edge; acceptance is recorded at that cycle's edge.
  task automatic drive(input logic v, input logic [DATAW-1:0] d, input logic [N-1:0] s,
                       output logic acc);
    bus.valid_in  = v;
    bus.data_in   = d;
    bus.sel_in    = s;
    bus.ready_out = rdy_rand ? N'($urandom) : rdy_fix;
    @(negedge clk);
    acc = v & bus.ready_in;
    @(posedge clk);
    if (acc) begin
      if (s != '0) q.push_back('{lane_of(s), d});
      if ($countones(s) != 1) exp_err = 1'b1;
    end
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int k = 0; k < n; k++) drive(1'b0, '0, '0, a);
  endtask

  task automatic send(input logic [DATAW-1:0] d, input logic [N-1:0] s, output int tries);
    logic a;
    tries = 0;
    a = 1'b0;
    while (!a && tries < 200) begin
      drive(1'b1, d, s, a);
      tries++;
    end
    if (!a) chk("send_timeout", 32'(tries), 32'(0));
  endtask

  // Monitor: expectation for this cycle comes from the head of the FIFO model, popped on delivery.
  always @(negedge clk) begin : monitor
    logic [N-1:0] ev;
    logic         er;
    ev = '0;
    if (q.size() > 0) ev[q[0].lane] = 1'b1;
    chk("valid_out", 32'(bus.valid_out), 32'(ev));
`ifdef ONEHOT_DEMUX_SKID_EN
    er = (q.size() < 2);
`else
    er = (q.size() == 0) || bus.ready_out[q[0].lane];
`endif
    chk("ready_in", 32'(bus.ready_in), 32'(er));
    chk("sel_err", 32'(bus.sel_err), 32'(exp_err));
    if (q.size() > 0) begin
      chk("data_out", 32'(bus.data_out[q[0].lane]), 32'(q[0].data));
      if (bus.ready_out[q[0].lane]) void'(q.pop_front());
    end
  end

  initial begin
    #50_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int   tries;
    logic a;
    logic got;
    int   n_xfer;
    logic v;
    logic [DATAW-1:0] d;
    logic [N-1:0] s;
    int   r;

    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.sel_in    = '0;
    bus.ready_out = '1;
    #1;
    chk("reset_valid_out", 32'(bus.valid_out), 32'(0));
    chk("reset_sel_err", 32'(bus.sel_err), 32'(0));
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Back-to-back to three lanes with every consumer ready.
    rdy_fix = 4'b1111;
    send(8'h11, 4'b0001, tries); chk("b2b_tries0", 32'(tries), 32'(1));
    send(8'h22, 4'b0100, tries); chk("b2b_tries1", 32'(tries), 32'(1));
    send(8'h33, 4'b1000, tries); chk("b2b_tries2", 32'(tries), 32'(1));
    idle(2);

    // Lane 2 stalled; second transfer must wait (or land in the skid) and keep order.
    rdy_fix = 4'b1011;
    send(8'hAA, 4'b0100, tries);
    got = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!got) drive(1'b1, 8'hBB, 4'b0001, a);
      else      drive(1'b0, '0, '0, a);
      got |= a;
    end
`ifdef ONEHOT_DEMUX_SKID_EN
    chk("stall_accept", 32'(got), 32'(1));
`else
    chk("stall_accept", 32'(got), 32'(0));
`endif
    chk("stall_hold_lane", 32'(bus.valid_out), 32'(4'b0100));
    chk("stall_hold_data", 32'(bus.data_out[2]), 32'(8'hAA));
    rdy_fix = 4'b1111;
    if (!got) send(8'hBB, 4'b0001, tries);
    idle(3);

    // Multi-hot select: delivered on lowest lane, error flag becomes sticky.
    chk("err_before_bad", 32'(bus.sel_err), 32'(0));
    send(8'h55, 4'b0110, tries);
    idle(2);
    chk("err_after_multi", 32'(bus.sel_err), 32'(1));

    // Zero select: accepted immediately and dropped.
    send(8'h66, 4'b0000, tries);
    chk("zero_sel_tries", 32'(tries), 32'(1));
    idle(2);
    chk("zero_sel_no_out", 32'(bus.valid_out), 32'(0));
    send(8'h12, 4'b0010, tries);
    idle(2);
    chk("err_sticky", 32'(bus.sel_err), 32'(1));

    // Reset while an entry is held on lane 3.
    rdy_fix = 4'b0111;
    send(8'h77, 4'b1000, tries);
    idle(2);
    chk("held_77", 32'(bus.valid_out), 32'(4'b1000));
    @(posedge clk); #3;
    reset = 1'b1;
    q.delete();
    exp_err = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.valid_out), 32'(0));
    chk("async_rst_err", 32'(bus.sel_err), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    rdy_fix = 4'b1111;
    idle(3);

    // Random traffic: ~50% valid, per-lane random ready, occasional malformed selects.
    rdy_rand = 1'b1;
    n_xfer = 0;
    for (int c = 0; c < 60000 && n_xfer < 10000; c++) begin
      v = 1'($urandom_range(0, 1));
      d = DATAW'($urandom);
      r = $urandom_range(0, 15);
      if (r == 0)      s = '0;
      else if (r == 1) s = N'($urandom);
      else             s = N'(1) << $urandom_range(0, N - 1);
      drive(v, d, s, a);
      if (a) n_xfer++;
    end
    chk("rand_xfers", 32'(n_xfer >= 10000), 32'(1));

    rdy_rand = 1'b0;
    rdy_fix = '1;
    idle(5);
    chk("drain_empty", 32'(q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
